vga_frame_mem_arbiter: RTL and testbench
========================================

# vga_frame_mem_arbiter

Shares a single-port synchronous frame-buffer SRAM between the display pixel fetcher (which feeds the VGA timing generator's colour inputs) and the camera pixel writer. During active video, display reads have priority, with a bounded starvation guard for writes. During blanking, writes have priority. All SRAM control outputs are registered. Read data returns with a fixed latency.

## Interface
- ADDR_W, 19, SRAM word address width
- DATA_W, 24, pixel word width (R,G,B 8 bits each)
- STARVE_LIMIT, 8, consecutive read grants allowed while a write waits during active video; legal range 1..255
- Clock  in  1  system pixel clock; all logic on rising edge
- Reset  in  1  synchronous, active-low
- VideoBlanking_L  in  1  high = active video region, low = blanking
- rd_req  in  1  display read request; held until acked
- rd_addr  in  ADDR_W  read address; stable while rd_req is high
- rd_ack  out  1  combinational; read accepted this cycle
- rd_data  out  DATA_W  registered read data
- rd_data_valid  out  1  one-cycle pulse; rd_data is valid
- wr_valid  in  1  camera write request; holds until wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  combinational; write accepted this cycle
- mem_en  out  1  registered SRAM enable
- mem_we  out  1  registered write enable (1 = write)
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after the SRAM samples a read
- rd_stall_cnt  out  16  saturating count of cycles with rd_req high and rd_ack low

## Operation
- At most one grant per cycle. A transfer happens when rd_req&rd_ack or wr_valid&wr_ready.
- Mode ACTIVE (VideoBlanking_L=1):
  - If rd_req=1 and the starvation guard is not tripped, grant the read.
  - Otherwise grant the write if wr_valid=1.
- Mode BLANK (VideoBlanking_L=0):
  - If wr_valid=1, grant the write.
  - Otherwise grant the read if rd_req=1.
- Starvation counter starve_cnt is 8 bits:
  - Increments on each read grant while wr_valid=1.
  - Clears on any write grant, and in any cycle with wr_valid=0.
  - The guard is tripped when starve_cnt==STARVE_LIMIT. In that case the write is granted and rd_ack is held 0 that cycle.
  - The counter never exceeds STARVE_LIMIT.
- The mode is sampled per cycle, with no hysteresis. A mode change takes effect on the same cycle's grant decision.
- Read return pipeline: a 2-stage tag shift register, rd_pend[1:0], tracks issued reads. rd_data captures mem_rdata when the tag exits.
- rd_stall_cnt increments every cycle with rd_req=1 and rd_ack=0. It saturates at 16'hFFFF and clears only on Reset.
- Idle cycle (no grant): mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their previous values.
- Reset (Reset=0 on an edge), including mid-operation:
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rd_data=0, rd_data_valid=0, rd_pend=0, starve_cnt=0, rd_stall_cnt=0.
  - In-flight reads are discarded; no rd_data_valid is issued for them.
  - rd_ack and wr_ready are forced to 0 while Reset=0.

## Timing
- Cycle N: grant decided combinationally; rd_ack/wr_ready high in N.
- Edge ending N: mem_en=1, mem_we, mem_addr, mem_wdata registered; visible in N+1.
- Edge ending N+1: SRAM samples. For a write, the data is committed here.
- Cycle N+2: mem_rdata valid.
- Edge ending N+2: rd_data registered.
- Cycle N+3: rd_data_valid=1 for one cycle.
- Read latency is 3 cycles from ack to valid, for every read.
- Back-to-back reads every cycle give back-to-back rd_data_valid pulses in the same order.
- Read→write→read on consecutive cycles is legal; no turnaround bubble.
- Simultaneous rd_req and wr_valid with the guard tripped: the write wins. The read is acked at the earliest the next cycle, because starve_cnt is cleared by the write grant.

## Test plan
- Reset: drive Reset=0 mid-burst with two reads in flight. Required: mem_en=0 next cycle, no rd_data_valid afterwards, rd_stall_cnt=0.
- ACTIVE read stream: rd_req high for 20 cycles at addresses 0..19, wr_valid=0. Required: rd_ack every cycle. rd_data_valid pulses in cycles 3..22 relative to the first ack, with data matching the SRAM model.
- ACTIVE starvation (STARVE_LIMIT=8): rd_req and wr_valid both held high. Required:
  - 8 read acks, then 1 write ack with rd_ack=0 that cycle.
  - This pattern repeats.
  - rd_stall_cnt increments by 1 per write slot.
- BLANK priority: VideoBlanking_L=0, rd_req and wr_valid high for 4 writes. Required:
  - wr_ready for 4 cycles, then rd_ack.
  - Write data is visible in the SRAM model at the written addresses.
- Mode switch: VideoBlanking_L goes 0→1 while both requesters are high. Required: the grant switches from write to read on that same cycle, and starve_cnt starts at 0.
- Read-after-write: write 24'hA5A5A5 to address 0x100, then read address 0x100 on the next cycle. Required: rd_data=24'hA5A5A5, 3 cycles after the read ack.

Source files
------------

// File: rtl/vga_frame_mem_arbiter_if.sv
// Requester-side bus between the display fetcher / camera writer
// and the frame-buffer arbiter.
interface vga_frame_mem_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output rd_req, rd_addr,
    output wr_valid, wr_addr, wr_data,
    input  rd_ack, rd_data, rd_data_valid,
    input  wr_ready
  );

  modport slave (
    input  rd_req, rd_addr,
    input  wr_valid, wr_addr, wr_data,
    output rd_ack, rd_data, rd_data_valid,
    output wr_ready
  );
endinterface

// File: rtl/vga_frame_mem_arbiter.sv
// Single-port frame-buffer arbiter: display reads vs camera writes,
// mode-dependent priority, registered SRAM port, fixed read latency.
module vga_frame_mem_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 24,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              VideoBlanking_L,
  vga_frame_mem_arbiter_if.slave bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       rd_stall_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic              rd_gnt;
  logic              wr_gnt;
  logic              tripped;

  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic [1:0]        rd_pend_q,   rd_pend_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;
  logic              rd_vld_q,    rd_vld_d;
  logic [15:0]       stall_q,     stall_d;

  // Grant decision: reads lead in active video unless a waiting
  // write has been passed over LIMIT times; writes lead in blanking.
  always_comb begin
    rd_gnt  = 1'b0;
    wr_gnt  = 1'b0;
    tripped = (starve_cnt_q == LIMIT);
    if (Reset) begin
      if (VideoBlanking_L) begin
        rd_gnt = bus.rd_req & ~tripped;
        wr_gnt = ~rd_gnt & bus.wr_valid;
      end else begin
        wr_gnt = bus.wr_valid;
        rd_gnt = ~wr_gnt & bus.rd_req;
      end
    end
  end

  assign bus.rd_ack        = rd_gnt;
  assign bus.wr_ready      = wr_gnt;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_vld_q;
  assign mem_en            = mem_en_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign rd_stall_cnt      = stall_q;

  // Next-state: SRAM command, starvation count, return pipe, stalls.
  always_comb begin
    mem_en_d    = rd_gnt | wr_gnt;
    mem_we_d    = wr_gnt;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_gnt) begin
      mem_addr_d = bus.rd_addr;
    end
    if (wr_gnt) begin
      mem_addr_d  = bus.wr_addr;
      mem_wdata_d = bus.wr_data;
    end

    starve_cnt_d = starve_cnt_q;
    if (wr_gnt || !bus.wr_valid) begin
      starve_cnt_d = 8'd0;
    end else if (rd_gnt) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    rd_pend_d = {rd_pend_q[0], rd_gnt};
    rd_vld_d  = rd_pend_q[1];
    rd_data_d = rd_pend_q[1] ? mem_rdata : rd_data_q;

    stall_d = stall_q;
    if (bus.rd_req && !rd_gnt && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      starve_cnt_q <= 8'd0;
      rd_pend_q    <= 2'b00;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      stall_q      <= 16'd0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_mem_arbiter.sv
// Randomized bench for vga_frame_mem_arbiter against a
// transaction-level priority / memory model.
module tb_vga_frame_mem_arbiter;

  localparam int AW  = 19;
  localparam int DW  = 24;
  localparam int LIM = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          blank_l = 1'b1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   stall;

  always #5 Clock = ~Clock;

  vga_frame_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_frame_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .VideoBlanking_L(blank_l),
    .bus(bus),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rd_stall_cnt(stall)
  );

  // Synchronous single-port SRAM attached to the DUT.
  logic [DW-1:0] sram [0:1023];
  always @(posedge Clock) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[9:0]];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a * 24'h010203) ^ 24'h5A0000;
  endfunction

  // Reference model state.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } ret_t;

  logic [DW-1:0] shadow [0:1023];
  ret_t          rq[$];
  int            cyc;
  int            starve;
  int            stall_m;
  bit            exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  bit            last_rd, last_wr;
  int            rd_seq;

  task automatic step();
    bit   g_rd, g_wr, ev;
    ret_t r;
    g_rd = 1'b0;
    g_wr = 1'b0;
    if (Reset) begin
      if (blank_l) begin
        g_rd = bus.rd_req && (starve != LIM);
        g_wr = !g_rd && bus.wr_valid;
      end else begin
        g_wr = bus.wr_valid;
        g_rd = !g_wr && bus.rd_req;
      end
    end
    chk("rd_ack", 32'(bus.rd_ack), 32'(g_rd));
    chk("wr_ready", 32'(bus.wr_ready), 32'(g_wr));
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en) begin
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
    end
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    chk("rd_valid", 32'(bus.rd_data_valid), 32'(ev));
    if (ev) begin
      chk("rd_data", 32'(bus.rd_data), 32'(rq[0].d));
      void'(rq.pop_front());
    end
    chk("stall_cnt", 32'(stall), 32'(stall_m));

    if (!Reset) begin
      rq.delete();
      starve  = 0;
      stall_m = 0;
      exp_en  = 1'b0;
    end else begin
      if (bus.rd_req && !g_rd && stall_m < 65535) stall_m++;
      if (g_rd) begin
        r.due = cyc + 3;
        r.d   = shadow[bus.rd_addr[9:0]];
        rq.push_back(r);
        exp_addr = bus.rd_addr;
      end
      if (g_wr) begin
        shadow[bus.wr_addr[9:0]] = bus.wr_data;
        exp_addr = bus.wr_addr;
        exp_wd   = bus.wr_data;
      end
      if (g_wr || !bus.wr_valid) starve = 0;
      else if (g_rd) starve++;
      exp_en = g_rd || g_wr;
      exp_we = g_wr;
    end
    last_rd = g_rd;
    last_wr = g_wr;
    cyc++;
  endtask

  task automatic tick();
    @(negedge Clock);
    step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(7) == 0) return AW'(32'h100);
    return AW'($urandom_range(15));
  endfunction

  // Requesters obeying hold-until-accepted.
  task automatic drive(int prd, int pwr, int bmode, bit seq);
    if (bmode == 2) blank_l = 1'($urandom_range(1));
    else            blank_l = bmode[0];
    if (!bus.rd_req || last_rd) begin
      bus.rd_req = ($urandom_range(99) < prd);
      if (seq) begin
        bus.rd_addr = AW'(rd_seq);
        if (bus.rd_req) rd_seq++;
      end else begin
        bus.rd_addr = rand_addr();
      end
    end
    if (!bus.wr_valid || last_wr) begin
      bus.wr_valid = ($urandom_range(99) < pwr);
      bus.wr_addr  = rand_addr();
      bus.wr_data  = DW'($urandom);
    end
  endtask

  task automatic run(int n, int prd, int pwr, int bmode, bit seq);
    for (int i = 0; i < n; i++) begin
      drive(prd, pwr, bmode, seq);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]   = init_val(i);
      shadow[i] = init_val(i);
    end
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    cyc = 0; starve = 0; stall_m = 0;
    exp_en = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_wd = '0;
    last_rd = 1'b0; last_wr = 1'b0;
    rd_seq = 0;

    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    tick();
    Reset = 1'b1;

    // Active-video read stream at addresses 0..19.
    rd_seq = 0;
    run(20, 100, 0, 1, 1'b1);
    run(6, 0, 0, 1, 1'b0);

    // Active-video starvation: both requesters saturated.
    run(40, 100, 100, 1, 1'b0);
    run(15, 0, 0, 1, 1'b0);

    // Blanking: writes first, then the held read.
    run(4, 100, 100, 0, 1'b0);
    run(6, 0, 0, 0, 1'b0);

    // Blanking to active switch while both requesters are busy.
    run(3, 100, 100, 0, 1'b0);
    run(12, 100, 100, 1, 1'b0);
    run(15, 0, 0, 1, 1'b0);

    // Read-after-write on consecutive cycles.
    blank_l      = 1'b0;
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(32'h100);
    bus.wr_data  = 24'hA5A5A5;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b1;
    bus.rd_addr  = AW'(32'h100);
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();
    @(negedge Clock);
    chk("raw_valid", 32'(bus.rd_data_valid), 32'h1);
    chk("raw_data", 32'(bus.rd_data), 32'hA5A5A5);
    step();
    @(posedge Clock);
    #1;

    // Long randomized mix with random mode.
    run(1500, 60, 50, 2, 1'b0);
    run(15, 0, 0, 1, 1'b0);

    // Reset in the middle of a read burst.
    run(3, 100, 0, 1, 1'b1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge Clock);
    chk("rst_mid_en", 32'(mem_en), 32'h0);
    chk("rst_mid_stall", 32'(stall), 32'h0);
    step();
    @(posedge Clock);
    #1;
    run(6, 0, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
